fetch_stage: RTL

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 41 ++++
 rtl/fetch_stage_pc_gen.sv | 65 ++++++
 rtl/fetch_stage.sv | 95 +++++++++
 3 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared opcode and constant definitions for the fetch stage and the X-stage
// control unit: 5-bit opcode fields (inst[6:2]), bubble instruction,
// default reset PC, PC-select encoding and a J-immediate helper.
package fetch_stage_pkg;

  // Architectural defaults
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0000;
  localparam logic [31:0] NOP_INST_DEFAULT = 32'h0000_0013; // addi x0,x0,0

  // RV32I opcode fields, bits [6:2] of the instruction word
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OP_IMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM = 5'b11100;

  // Source selected for the next fetch address
  typedef enum logic [2:0] {
    PC_SEL_RESET    = 3'd0,
    PC_SEL_HOLD     = 3'd1,
    PC_SEL_REDIRECT = 3'd2,
    PC_SEL_JAL      = 3'd3,
    PC_SEL_SEQ      = 3'd4
  } pc_sel_e;

  // Sign-extended J-type immediate (byte offset, bit 0 always zero)
  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // True when the opcode field decodes as JAL
  function automatic logic is_jal(input logic [31:0] inst);
    return inst[6:2] == OPC_JAL;
  endfunction

endpackage

// File: rtl/fetch_stage_pc_gen.sv
// pc_gen: next-fetch-address priority mux and J-immediate adder.
// Priority: not live -> RESET_PC, stall -> hold, redirect -> target,
// early JAL -> pc + J-imm, otherwise pc + 4. All arithmetic wraps mod 2^32.
// Early JAL decode is only built when JAL_EARLY_EN is defined.
module pc_gen
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic [31:0] pc_d,
  input  logic        live_d,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] inst,
  output logic [31:0] pc_next,
  output logic        jal_taken
);

  pc_sel_e     pc_sel;
  logic [31:0] seq_pc;
  logic [31:0] jal_target;
  logic        unused_inst_bits;

  assign seq_pc     = pc_d + 32'd4;
  assign jal_target = pc_d + j_imm(inst);

  // rd and the low opcode bits never influence the fetch address
  assign unused_inst_bits = &{1'b0, inst};

`ifdef JAL_EARLY_EN
  // A JAL seen on the memory return path is followed immediately, unless an
  // older event (stall/redirect) owns the fetch address this cycle
  assign jal_taken = live_d && !stall && !redirect && is_jal(inst);
`else
  assign jal_taken = 1'b0;
`endif

  // Pick the source of the next fetch address by priority
  always_comb begin
    pc_sel = PC_SEL_SEQ;
    if (!live_d) begin
      pc_sel = PC_SEL_RESET;
    end else if (stall) begin
      pc_sel = PC_SEL_HOLD;
    end else if (redirect) begin
      pc_sel = PC_SEL_REDIRECT;
    end else if (jal_taken) begin
      pc_sel = PC_SEL_JAL;
    end
  end

  // Drive the selected address
  always_comb begin
    pc_next = seq_pc;
    case (pc_sel)
      PC_SEL_RESET:    pc_next = RESET_PC;
      PC_SEL_HOLD:     pc_next = pc_d;
      PC_SEL_REDIRECT: pc_next = redirect_pc;
      PC_SEL_JAL:      pc_next = jal_target;
      default:         pc_next = seq_pc;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch for a two-stage pipeline with a
// synchronous-read instruction memory. pc_d is the address whose data is on
// imem_rdata this cycle; live_d marks that data as real. The X register feeds
// the execute stage. Optional macro JAL_EARLY_EN enables zero-bubble JAL
// following in fetch (x_predicted flags such instructions).
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] x_inst,
  output logic [31:0] x_pc,
  output logic        x_valid,
  output logic        x_predicted
);

  logic [31:0] pc_d;
  logic        live_d;
  logic [31:0] pc_next;
  logic        jal_taken;
  logic        x_load;

  pc_gen #(
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .pc_d        (pc_d),
    .live_d      (live_d),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst        (imem_rdata),
    .pc_next     (pc_next),
    .jal_taken   (jal_taken)
  );

  // Memory is addressed with the next PC so its data lines up with pc_d
  assign imem_addr = pc_next;

  // The fetched word is real unless it is still reset garbage or was fetched
  // on the path a redirect is abandoning
  assign x_load = live_d && !redirect;

  // Track the address whose data is returning, and whether it is real
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_d   <= RESET_PC;
      live_d <= 1'b0;
    end else begin
      pc_d   <= pc_next;
      live_d <= 1'b1;
    end
  end

  // X register: hold on stall, load the fetched word or insert a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_inst  <= NOP_INST;
      x_pc    <= '0;
      x_valid <= 1'b0;
    end else if (!stall) begin
      x_pc <= pc_d;
      if (x_load) begin
        x_inst  <= imem_rdata;
        x_valid <= 1'b1;
      end else begin
        x_inst  <= NOP_INST;
        x_valid <= 1'b0;
      end
    end
  end

`ifdef JAL_EARLY_EN
  // Flag JALs already followed in fetch; only ever set alongside x_valid
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_predicted <= 1'b0;
    end else if (!stall) begin
      x_predicted <= x_load && jal_taken;
    end
  end
`else
  logic unused_jal_taken;
  assign unused_jal_taken = jal_taken;
  assign x_predicted      = 1'b0;
`endif

endmodule
